// File: rtl/serial_adder.sv
// Bit-serial adder: one fullAdder processes one operand bit pair per clock, LSB first.
// Operands enter and the {cout, sum} result leaves through valid/ready handshakes.
module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             fa_s, fa_c;

    fullAdder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shift form instead of a part-select so WIDTH=1 elaborates cleanly
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_c;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances share one clock and reset.
module tb_serial_adder;
    localparam int unsigned W = 8;
    localparam int unsigned N_RAND = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         v1, r1, ov1, or1, a1, b1, c1, s1, co1, busy1;

    int           errors = 0;
    int           checks = 0;
    logic [W:0]   exp_q[$];
    logic [1:0]   exp1_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .a(a1), .b(b1), .cin(c1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .busy(busy1)
    );

    // Called at edge+1 while in_ready=1; returns at edge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        exp_q.push_back({1'b0, ta} + {1'b0, tb} + (W+1)'(tc));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
    endtask

    task automatic test_reset;
        logic [W+3:0] st;
        #2;
        st = {in_ready, out_valid, busy, cout, sum};
        checks++;
        if (st !== {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}}) begin
            errors++; $display("FAIL reset8: got %h expected %h", st, {1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
        end
        checks++;
        if ({r1, ov1, busy1, co1, s1} !== 5'b10000) begin
            errors++; $display("FAIL reset1: got %b expected 10000", {r1, ov1, busy1, co1, s1});
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [W:0] e;
        out_ready = 1'b1;
        send(8'h5A, 8'h3C, 1'b0);
        for (int i = 1; i < W; i++) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL lat_early: got valid=%b busy=%b expected valid=0 busy=1", out_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL lat_rise: got valid=%b expected 1", out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
            errors++; $display("FAIL basic_sum: got %h expected %h", {cout, sum}, e);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_rdy_done: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got rdy=%b valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_carry;
        logic [W:0] e;
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        logic tc[2];
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb[1] = 8'hFF; tc[1] = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send(ta[k], tb[k], tc[k]);
            for (int i = 0; i < 4 * W && out_valid !== 1'b1; i++) begin
                @(posedge clk); #1;
            end
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {cout, sum} !== e) begin
                errors++; $display("FAIL carry_%0d: got valid=%b %h expected valid=1 %h", k, out_valid, {cout, sum}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [W:0] e;
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1);
        for (int i = 1; i < W; i++) @(posedge clk);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== e) begin
                errors++; $display("FAIL bp_hold_%0d: got valid=%b rdy=%b %h expected 1 0 %h", c, out_valid, in_ready, {cout, sum}, e);
            end
            if (c == 2) begin
                in_valid = 1'b1; a = 8'hAA; b = 8'h00; cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got valid=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_no_ghost: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [W:0] e;
        out_ready = 1'b1;
        send(8'hF0, 8'h0F, 1'b0);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {cout, sum} !== '0) begin
            errors++; $display("FAIL rst_async: got valid=%b rdy=%b busy=%b %h expected 0 1 0 0", out_valid, in_ready, busy, {cout, sum});
        end
        exp_q.delete();
        #1 rst = 1'b0;
        send(8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 4 * W && out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {cout, sum} !== e) begin
            errors++; $display("FAIL rst_next: got valid=%b %h expected valid=1 %h", out_valid, {cout, sum}, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width1;
        logic [1:0] e;
        logic [2:0] in3;
        or1 = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            in3 = 3'(k);
            a1 = in3[2]; b1 = in3[1]; c1 = in3[0]; v1 = 1'b1;
            exp1_q.push_back(2'(a1) + 2'(b1) + 2'(c1));
            @(posedge clk); #1;
            v1 = 1'b0; a1 = ~a1; b1 = ~b1; c1 = ~c1;
            checks++;
            if (ov1 !== 1'b0 || busy1 !== 1'b1) begin
                errors++; $display("FAIL w1_run_%0d: got valid=%b busy=%b expected 0 1", k, ov1, busy1);
            end
            @(posedge clk); #1;
            e = exp1_q.pop_front();
            checks++;
            if (ov1 !== 1'b1 || {co1, s1} !== e) begin
                errors++; $display("FAIL w1_sum_%0d: got valid=%b %b expected valid=1 %b", k, ov1, {co1, s1}, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [W:0] e;
        exp_q.delete();
        out_ready = 1'b0;
        while (got < N_RAND && cyc < N_RAND * 40) begin
            cyc++;
            in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_dup: got result %h expected none", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin
                        errors++; $display("FAIL b2b_sum_%0d: got %h expected %h", got, {cout, sum}, e);
                    end
                end
                got++;
            end
            if (in_ready === 1'b1 && sent < N_RAND) begin
                a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
                in_valid = 1'b1;
                exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
                sent++;
            end else if (in_ready === 1'b0) begin
                in_valid = 1'($urandom());
                a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != N_RAND || sent != N_RAND || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: got sent=%0d recv=%0d left=%0d expected %0d %0d 0", sent, got, exp_q.size(), N_RAND, N_RAND);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        v1 = 1'b0; or1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        test_reset;
        test_basic;
        test_carry;
        test_backpressure;
        test_reset_mid_run;
        test_width1;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
